vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer memory between two requesters: the display line prefetch and a plot writer that draws pulse-compression results.
- Display prefetch always wins. On each line request it copies one display line of words into a ping-pong line buffer, which the pixel path then reads.
- The plot writer uses the memory cycles left over in each 800-clock line, through a req/ack handshake.
- Sits between the VGA timing generator, the plot/render logic and the frame-buffer RAM.

Parameters:
- DATA_W, 32, memory word width (4 x 8-bit pixels).
- ADDR_W, 17, frame-buffer word-address width.
- WORDS_PER_LINE, 160, words fetched per visible line (640 px / 4).
- LINES, 480, number of visible lines; a line_y at or above this is not fetched.
- LB_AW, 8, line-buffer index width; the line buffer is addressed with LB_AW+1 bits, MSB = bank.
- FB_BASE, 0, word address of line 0.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- line_req  in  1  one-cycle pulse: prefetch line line_y.
- line_y  in  10  line to fetch; sampled only when line_req=1.
- wr_req  in  1  plot write request; held until wr_ack.
- wr_addr  in  ADDR_W  plot write address; stable while wr_req=1.
- wr_data  in  DATA_W  plot write data; stable while wr_req=1.
- wr_ack  out  1  one-cycle pulse: the write is performed this cycle.
- mem_addr  out  ADDR_W  frame-buffer address.
- mem_we  out  1  frame-buffer write enable.
- mem_wdata  out  DATA_W  frame-buffer write data.
- mem_rdata  in  DATA_W  read data, valid 1 cycle after its address.
- lb_we  out  1  line-buffer write enable.
- lb_addr  out  LB_AW+1  line-buffer address = {line_y[0], word index}.
- lb_wdata  out  DATA_W  line-buffer write data = mem_rdata.
- fetch_busy  out  1  high while the FETCH or DRAIN state is active.
- underrun  out  1  sticky flag: a fetch was aborted by a new line_req.

Behaviour:
- Reset values (async, reset_n=0):
  - State = IDLE; all outputs 0, including underrun.
  - Internal index, base address and bank registers are cleared.
- States: IDLE, WRITE, FETCH, DRAIN.
- IDLE:
  - line_req=1 and line_y<LINES: latch base = FB_BASE + line_y*WORDS_PER_LINE and bank = line_y[0]; set idx=0; go to FETCH.
  - line_req=1 and line_y>=LINES: ignored; no fetch, no flag.
  - If neither of the above and wr_req=1: latch wr_addr and wr_data; go to WRITE.
  - line_req wins when it arrives together with wr_req. The writer keeps wr_req high and is served after the fetch.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr and mem_wdata = latched values, wr_ack=1; then IDLE.
  - A line_req arriving in WRITE is held in a one-deep pending register; IDLE acts on it the next cycle, ahead of wr_req.
  - wr_req is ignored during its own ack cycle. Minimum spacing between acks is 2 cycles.
- FETCH:
  - mem_we=0, mem_addr = base+idx, idx increments each cycle.
  - After the cycle with idx = WORDS_PER_LINE-1, go to DRAIN.
  - Each read returns one cycle later: lb_we=1, lb_addr={bank, idx_delayed}, lb_wdata=mem_rdata.
- DRAIN (1 cycle): completes the last lb write; mem bus idle; then IDLE.
- Latency, with line_req sampled at cycle t:
  - First mem_addr at t+1.
  - First lb_we at t+2.
  - Last lb_we at t+1+WORDS_PER_LINE.
  - fetch_busy high from t+1 to t+1+WORDS_PER_LINE inclusive.
- line_req during FETCH or DRAIN: abort the current fetch, set underrun=1 (stays set until reset), and load the new line exactly as IDLE would. The new FETCH starts the next cycle.
- The pipeline register for the final read of an aborted fetch still completes its lb write into the old bank.
- Index and address arithmetic: unsigned, ADDR_W bits; the base product is computed once per fetch.
- wr_ack is never asserted in FETCH or DRAIN.
- mem_we and lb_we are never asserted in the same cycle.
- Reset asserted mid-operation returns everything to the reset values immediately; any pending line_req and latched write are discarded.

Test Plan:
1. Reset, then line_req with line_y=5 -> mem_addr 800..959 on 160 consecutive cycles from t+1. lb_we over t+2..t+161 with lb_addr {1,0..159}. fetch_busy high for 161 cycles. underrun=0.
2. wr_req held with wr_addr=0x1234, wr_data=0xDEADBEEF, in IDLE -> one cycle later mem_we=1 with those values and wr_ack=1; state back to IDLE.
3. wr_req and line_req (line_y=2) in the same cycle -> fetch of addresses 320..479 first. wr_ack arrives on the second cycle after DRAIN ends.
4. line_req (line_y=10) while in WRITE -> the write completes with wr_ack. The fetch of 1600.. starts 2 cycles after the pulse.
5. line_req (line_y=7) at idx=50 of the line-6 fetch -> underrun=1 and stays 1. The next cycle mem_addr=1120 and the line-7 fetch runs to completion.
6. line_req with line_y=480, then reset_n pulsed low mid-fetch -> no fetch for 480. After reset all outputs are 0 and underrun=0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares a single-port frame buffer between the display line
//            prefetch (always wins) and a plot writer (req/ack handshake).
//            Fetched lines land in a ping-pong line buffer selected by
//            line_y[0].
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 17,
  parameter int WORDS_PER_LINE = 160,
  parameter int LINES          = 480,
  parameter int LB_AW          = 8,
  parameter int FB_BASE        = 0
) (
  input  logic              i_vga_clk,
  input  logic              i_reset_n,
  input  logic              i_line_req,
  input  logic [9:0]        i_line_y,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_lb_we,
  output logic [LB_AW:0]    o_lb_addr,
  output logic [DATA_W-1:0] o_lb_wdata,
  output logic              o_fetch_busy,
  output logic              o_underrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FETCH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [LB_AW-1:0] c_LAST_IDX = LB_AW'(WORDS_PER_LINE - 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_base;
  logic [LB_AW-1:0]  r_idx;
  logic              r_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_pend;
  logic [9:0]        r_pend_y;
  logic              r_rd_valid;
  logic [LB_AW-1:0]  r_rd_idx;
  logic              r_rd_bank;
  logic              r_underrun;

  logic              w_req_any;
  logic              w_req_ok;
  logic [9:0]        w_req_y;
  logic [ADDR_W-1:0] w_new_base;
  logic              w_load;
  logic              w_abort;
  logic              w_take_wr;

  // Effective line request: a live pulse beats one parked during a WRITE cycle
  always_comb begin
    w_req_any  = i_line_req | r_pend;
    w_req_y    = i_line_req ? i_line_y : r_pend_y;
    w_req_ok   = w_req_any && (32'(w_req_y) < 32'(LINES));
    w_new_base = ADDR_W'(FB_BASE) + ADDR_W'(w_req_y) * ADDR_W'(WORDS_PER_LINE);
  end

  // Next-state decision and memory/line-buffer bus outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_abort      = 1'b0;
    w_take_wr    = 1'b0;
    o_wr_ack     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;

    case (r_state)
      S_IDLE: begin
        if (w_req_ok) begin
          w_load      = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (!w_req_any && i_wr_req) begin
          w_take_wr   = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_we    = 1'b1;
        o_wr_ack    = 1'b1;
        o_mem_addr  = r_wr_addr;
        o_mem_wdata = r_wr_data;
        w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        o_mem_addr = r_base + ADDR_W'(r_idx);
        if (w_req_ok) begin
          w_load      = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (r_idx == c_LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_req_ok) begin
          w_load      = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    o_fetch_busy = (r_state == S_FETCH) || (r_state == S_DRAIN);
    o_lb_we      = r_rd_valid;
    o_lb_addr    = r_rd_valid ? {r_rd_bank, r_rd_idx} : '0;
    o_lb_wdata   = r_rd_valid ? i_mem_rdata : '0;
    o_underrun   = r_underrun;
  end

  // State register
  always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Fetch pointers, latched write, parked line request and read pipeline
  always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base     <= '0;
      r_idx      <= '0;
      r_bank     <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_pend     <= 1'b0;
      r_pend_y   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= '0;
      r_rd_bank  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_base <= w_new_base;
        r_bank <= w_req_y[0];
        r_idx  <= '0;
      end else if (r_state == S_FETCH) begin
        r_idx  <= r_idx + LB_AW'(1);
      end

      if (w_take_wr) begin
        r_wr_addr <= i_wr_addr;
        r_wr_data <= i_wr_data;
      end

      // WRITE is always followed by IDLE, which consumes the parked request
      r_pend <= (r_state == S_WRITE) && i_line_req;
      if ((r_state == S_WRITE) && i_line_req) r_pend_y <= i_line_y;

      // Read data returns one cycle later; the old bank/index travel with it
      r_rd_valid <= (r_state == S_FETCH);
      r_rd_idx   <= r_idx;
      r_rd_bank  <= r_bank;

      if (w_abort) r_underrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire
